// File: rtl/tone_burst_gen.sv
// ============================================================================
// Module      : tone_burst_gen
// Description : Square-wave tone-burst generator for a differential
//               transducer drive. It produces a burst, then a post-burst
//               holdoff, then a one-clock completion pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tone_burst_gen #(
    parameter int DIV_W  = 16,
    parameter int CNT_W  = 8,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [DIV_W-1:0]  half_period,
    input  logic [CNT_W-1:0]  n_cycles,
    input  logic [HOLD_W-1:0] holdoff,
    output logic              wave_p,
    output logic              wave_n,
    output logic              busy,
    output logic              rx_blank,
    output logic              done
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_burst   = 2'd1;
    localparam logic [1:0] c_holdoff = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [DIV_W-1:0]  lvl_q,     lvl_d;
    logic [CNT_W:0]    half_q,    half_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [DIV_W-1:0]  h_q,       h_d;
    logic [CNT_W-1:0]  n_q,       n_d;
    logic [HOLD_W-1:0] d_q,       d_d;
    logic              phase_q,   phase_d;
    logic              wave_p_q,  wave_p_d;
    logic              wave_n_q,  wave_n_d;
    logic              busy_q,    busy_d;
    logic              rx_blank_q, rx_blank_d;
    logic              done_q,    done_d;

    logic              w_accept;
    logic              w_done_evt;
    logic [CNT_W:0]    w_last_half;

    assign w_accept    = start && !abort && (half_period != '0) && (n_cycles != '0);
    assign w_last_half = {n_q, 1'b0};

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= c_idle;
            lvl_q      <= '0;
            half_q     <= '0;
            hold_q     <= '0;
            h_q        <= '0;
            n_q        <= '0;
            d_q        <= '0;
            phase_q    <= 1'b0;
            wave_p_q   <= 1'b0;
            wave_n_q   <= 1'b0;
            busy_q     <= 1'b0;
            rx_blank_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            half_q     <= half_d;
            hold_q     <= hold_d;
            h_q        <= h_d;
            n_q        <= n_d;
            d_q        <= d_d;
            phase_q    <= phase_d;
            wave_p_q   <= wave_p_d;
            wave_n_q   <= wave_n_d;
            busy_q     <= busy_d;
            rx_blank_q <= rx_blank_d;
            done_q     <= done_d;
        end
    end

    // Next state: counters hold the 1-based position of the current clock
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        half_d     = half_q;
        hold_d     = hold_q;
        h_d        = h_q;
        n_d        = n_q;
        d_d        = d_q;
        phase_d    = phase_q;
        w_done_evt = 1'b0;

        case (state_q)
            c_idle: begin
                if (w_accept) begin
                    state_d = c_burst;
                    h_d     = half_period;
                    n_d     = n_cycles;
                    d_d     = holdoff;
                    lvl_d   = DIV_W'(1);
                    half_d  = (CNT_W+1)'(1);
                    phase_d = 1'b1;
                end
            end
            c_burst: begin
                if (abort) begin
                    state_d = c_idle;
                    lvl_d   = '0;
                    half_d  = '0;
                    phase_d = 1'b0;
                end else if (lvl_q == h_q) begin
                    if (half_q == w_last_half) begin
                        lvl_d   = '0;
                        half_d  = '0;
                        phase_d = 1'b0;
                        if (d_q == '0) begin
                            state_d    = c_idle;
                            w_done_evt = 1'b1;
                        end else begin
                            state_d = c_holdoff;
                            hold_d  = HOLD_W'(1);
                        end
                    end else begin
                        lvl_d   = DIV_W'(1);
                        half_d  = half_q + (CNT_W+1)'(1);
                        phase_d = ~phase_q;
                    end
                end else begin
                    lvl_d = lvl_q + DIV_W'(1);
                end
            end
            c_holdoff: begin
                if (abort) begin
                    state_d = c_idle;
                    hold_d  = '0;
                end else if (hold_q == d_q) begin
                    state_d    = c_idle;
                    hold_d     = '0;
                    w_done_evt = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = c_idle;
                lvl_d   = '0;
                half_d  = '0;
                hold_d  = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register with zero lag
    always_comb begin
        busy_d     = (state_d != c_idle);
        rx_blank_d = (state_d != c_idle);
        wave_p_d   = (state_d == c_burst) &&  phase_d;
        wave_n_d   = (state_d == c_burst) && !phase_d;
        done_d     = w_done_evt;
    end

    assign wave_p   = wave_p_q;
    assign wave_n   = wave_n_q;
    assign busy     = busy_q;
    assign rx_blank = rx_blank_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: doc/tone_burst_gen.md
TONE_BURST_GEN -- requirements
Module: tone_burst_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the half-period setting.
REQ-002 SHALL have parameter CNT_W, default 8: width of the burst cycle-count setting.
REQ-003 SHALL have parameter HOLD_W, default 16: width of the post-burst holdoff setting.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: request a burst; sampled on the rising edge.
REQ-007 SHALL have port abort, input, 1: terminate any activity.
REQ-008 SHALL have port half_period, input, DIV_W: clocks per output level, H.
REQ-009 SHALL have port n_cycles, input, CNT_W: full square-wave cycles per burst, N.
REQ-010 SHALL have port holdoff, input, HOLD_W: idle-output clocks after the burst, D.
REQ-011 SHALL have port wave_p, output, 1: transducer drive, positive leg, registered.
REQ-012 SHALL have port wave_n, output, 1: transducer drive, negative leg, registered.
REQ-013 SHALL have port busy, output, 1: high in BURST and HOLDOFF, registered.
REQ-014 SHALL have port rx_blank, output, 1: receiver blanking, equal to busy, registered.
REQ-015 SHALL have port done, output, 1: one-clock completion pulse, registered.

Function
REQ-016 SHALL implement states IDLE, BURST and HOLDOFF.
REQ-017 In IDLE, start=1 with H>=1 and N>=1 and abort=0 SHALL be accepted at that edge; H, N and D are latched, and the state becomes BURST.
REQ-018 start with H=0 or N=0 SHALL be ignored: state stays IDLE and no done pulse is issued.
REQ-019 half_period, n_cycles and holdoff SHALL be sampled only at an accepted start; later changes SHALL have no effect on the running burst.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 At the accepting edge, outputs SHALL become busy=1, rx_blank=1, wave_p=1, wave_n=0, so there is zero added latency.
REQ-022 In BURST, each level SHALL last exactly H clocks.
REQ-023 In BURST, wave_n SHALL always equal ~wave_p.
REQ-024 BURST SHALL last exactly 2*N*H clocks; it starts with wave_p high and ends with wave_p low.
REQ-025 The level counter SHALL be DIV_W bits and the half-cycle counter SHALL be CNT_W+1 bits, so that no wrap occurs at maximum settings.
REQ-026 After BURST, wave_p=wave_n=0; the state SHALL be HOLDOFF for exactly D clocks, or go straight to IDLE if D=0.
REQ-027 On entering IDLE after completion, done=1 for exactly one clock, with busy=0 and rx_blank=0 in that same clock.
REQ-028 A start present during the done clock SHALL be accepted; the new burst begins with no gap beyond that one IDLE clock.
REQ-029 abort=1 in BURST or HOLDOFF SHALL force the next state to IDLE with wave_p=wave_n=0, busy=0, rx_blank=0 and done=0.
REQ-030 abort and start high in the same clock in IDLE: abort SHALL win and start is ignored.
REQ-031 In IDLE, both legs SHALL be 0, so the transducer is never driven statically.
REQ-032 wave_p and wave_n SHALL never be 1 at the same time.

Reset
REQ-033 rstn=0 SHALL asynchronously force state=IDLE, all counters to 0 and wave_p=wave_n=busy=rx_blank=done=0, including mid-burst.
REQ-034 After rstn deasserts, the first start SHALL be accepted no earlier than the first rising edge at which rstn is sampled high.
REQ-035 No done pulse SHALL be produced as a result of reset.

Verification
REQ-036 Basic burst: H=3, N=2, D=0, pulse start -> wave_p=111000111000 over 12 clocks, wave_n its complement, busy high 12 clocks, done on clock 13.
REQ-037 Holdoff: H=1, N=1, D=5 -> wave_p=10, then 5 clocks with both legs 0 and rx_blank=1; busy high 7 clocks, done on clock 8.
REQ-038 Illegal settings and early restart:
- start with H=0, then with N=0 -> no busy, no done.
- start held high during a burst -> ignored until the done clock, then a new burst begins.
REQ-039 Abort: abort on clock 4 of an H=2, N=4 burst -> next clock has all outputs 0, no done pulse, and a following start is accepted normally.
REQ-040 Reset mid-burst: rstn low for 1 clock in the middle of a burst -> outputs go to 0 immediately (asynchronously) and no done pulse follows.
REQ-041 Maximum settings: H=2^DIV_W-1, N=2^CNT_W-1 (short DIV_W build) -> exact 2*N*H burst length with no counter wrap.
